// File: rtl/la_seq_pkg.sv
// Shared encodings for the logic-analyser pattern sequencer: pattern modes,
// controller states and the first pattern each mode emits.
package la_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_GRAY  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Wide enough for any port width up to 64; users slice the low WIDTH bits.
    localparam logic [63:0] FIRST_COUNT = 64'h0;
    localparam logic [63:0] FIRST_WALK  = 64'h1;
    localparam logic [63:0] FIRST_GRAY  = 64'h0;
    localparam logic [63:0] FIRST_ALT   = {32{2'b01}};

endpackage

// File: rtl/la_pattern_gen.sv
// Pattern generator: loads the first pattern of the selected mode and steps
// to the next one on request. Keeps a binary step count to derive GRAY codes.
module la_pattern_gen
    import la_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pattern
);

    mode_e            mode_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] first_pat;
    logic [WIDTH-1:0] next_pat;

    always_comb begin
        bin_inc   = bin_q + WIDTH'(1);
        first_pat = '0;
        next_pat  = pattern;
        case (mode_e'(mode))
            MODE_COUNT: first_pat = FIRST_COUNT[WIDTH-1:0];
            MODE_WALK:  first_pat = FIRST_WALK[WIDTH-1:0];
            MODE_GRAY:  first_pat = FIRST_GRAY[WIDTH-1:0];
            MODE_ALT:   first_pat = FIRST_ALT[WIDTH-1:0];
            default:    first_pat = '0;
        endcase
        // The latched mode decides stepping, so mid-burst mode changes are ignored.
        case (mode_q)
            MODE_COUNT: next_pat = pattern + WIDTH'(1);
            MODE_WALK:  next_pat = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            MODE_GRAY:  next_pat = bin_inc ^ (bin_inc >> 1);
            MODE_ALT:   next_pat = ~pattern;
            default:    next_pat = pattern;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= '0;
            bin_q   <= '0;
            mode_q  <= MODE_COUNT;
        end else if (load) begin
            pattern <= first_pat;
            bin_q   <= '0;
            mode_q  <= mode_e'(mode);
        end else if (advance) begin
            pattern <= next_pat;
            bin_q   <= bin_inc;
        end
    end

endmodule

// File: rtl/la_pattern_sequencer.sv
// Start/stop controlled burst sequencer for the analyser header: FSM, step-rate
// divider and burst counter, driving a pattern generator.
module la_pattern_sequencer
    import la_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16,
    parameter int BURST_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BURST_W-1:0]    burst_len,
    output logic [WIDTH-1:0]      port,
    output logic                  step_stb,
    output logic                  sync,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] div_q, div_d, prescale_q;
    logic [BURST_W-1:0]    cnt_q, cnt_d, burst_q;
    logic                  step_d, sync_d, busy_d, done_d;
    logic                  load, advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            prescale_q <= '0;
            burst_q    <= '0;
            step_stb   <= 1'b0;
            sync       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            step_stb <= step_d;
            sync     <= sync_d;
            busy     <= busy_d;
            done     <= done_d;
            if (load) begin
                prescale_q <= prescale;
                burst_q    <= burst_len;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        sync_d  = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    load    = 1'b1;
                    sync_d  = 1'b1;
                    step_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = BURST_W'(1);
                    div_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident tick; a zero burst length runs until stopped.
                if (stop) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (div_q == prescale_q) begin
                    div_d = '0;
                    if ((burst_q != '0) && (cnt_q == burst_q)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        step_d  = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + BURST_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + PRESCALE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    la_pattern_gen #(
        .WIDTH(WIDTH)
    ) u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .mode    (mode),
        .pattern (port)
    );

endmodule

// File: tb/tb_la_pattern_sequencer.sv
// Scoreboard bench for la_pattern_sequencer: expected patterns are queued when a
// burst is started and popped on every step strobe.
module tb_la_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] prescale = 16'd0;
    logic [15:0] burst_len = 16'd0;
    logic [7:0]  port;
    logic        step_stb, sync, busy, done;

    typedef struct packed {
        logic [7:0] pat;
        logic       first;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    la_pattern_sequencer #(
        .WIDTH(8),
        .PRESCALE_W(16),
        .BURST_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .prescale  (prescale),
        .burst_len (burst_len),
        .port      (port),
        .step_stb  (step_stb),
        .sync      (sync),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] expPattern(input logic [1:0] m, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (m)
            2'd0:    return b;
            2'd1:    return 8'(1 << (i % 8));
            2'd2:    return b ^ (b >> 1);
            default: return ((i % 2) == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            checkOutput("done_excl", {30'd0, step_stb, sync}, 32'd0);
        end
        if (sync && !step_stb) checkOutput("sync_wo_stb", 32'(step_stb), 32'd1);
        if (step_stb) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                checkOutput("port", 32'(port), 32'(e.pat));
                checkOutput("sync", 32'(sync), 32'(e.first));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input int p, input int n, input int nexp);
        @(negedge clk);
        mode      = m;
        prescale  = 16'(p);
        burst_len = 16'(n);
        start     = 1'b1;
        for (int i = 0; i < nexp; i++) sb_q.push_back('{pat: expPattern(m, i), first: (i == 0)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic waitSteps(input int target, input int budget, output int steps);
        int n = 0;
        steps = step_stb ? 1 : 0;
        while (steps < target && n < budget) begin
            @(negedge clk);
            n++;
            if (step_stb) steps++;
        end
    endtask

    initial begin
        int b0, d0, steps;

        repeat (2) @(negedge clk);
        checkOutput("rst_port", 32'(port), 32'd0);
        checkOutput("rst_flags", {28'd0, step_stb, sync, busy, done}, 32'd0);
        rst = 1'b0;

        // Test 1: COUNT, P=0, N=4
        b0 = busy_cnt;
        applyStimulus(2'd0, 0, 4, 4);
        waitDone(20, "t1");
        checkOutput("t1_busy_cycles", 32'(busy_cnt - b0), 32'd4);
        checkOutput("t1_busy_at_done", 32'(busy), 32'd0);
        checkOutput("t1_port_held", 32'(port), 32'h03);
        checkOutput("t1_sb_left", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_port_idle", 32'(port), 32'h03);

        // Test 2: WALK, P=2, N=9
        b0 = busy_cnt;
        applyStimulus(2'd1, 2, 9, 9);
        waitDone(60, "t2");
        checkOutput("t2_busy_cycles", 32'(busy_cnt - b0), 32'd27);
        checkOutput("t2_port_held", 32'(port), 32'h01);
        checkOutput("t2_sb_left", 32'(sb_q.size()), 32'd0);
        @(negedge clk);

        // Test 3: GRAY continuous, stop after the 258th step
        b0 = busy_cnt;
        d0 = done_cnt;
        applyStimulus(2'd2, 0, 0, 258);
        waitSteps(258, 400, steps);
        checkOutput("t3_steps", 32'(steps), 32'd258);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_no_step", 32'(step_stb), 32'd0);
        checkOutput("t3_port_held", 32'(port), 32'h01);
        checkOutput("t3_busy_cycles", 32'(busy_cnt - b0), 32'd258);
        @(negedge clk);

        // Test 4: ALT, P=1, N=3 with a re-start and config change mid-burst
        b0 = busy_cnt;
        applyStimulus(2'd3, 1, 3, 3);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; prescale = 16'd0; burst_len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        waitDone(30, "t4");
        checkOutput("t4_busy_cycles", 32'(busy_cnt - b0), 32'd6);
        checkOutput("t4_port_held", 32'(port), 32'h55);
        checkOutput("t4_sb_left", 32'(sb_q.size()), 32'd0);
        @(negedge clk);

        // Test 5: reset mid-burst, then a fresh burst
        d0 = done_cnt;
        applyStimulus(2'd0, 3, 10, 10);
        waitSteps(5, 100, steps);
        checkOutput("t5_steps", 32'(steps), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        checkOutput("t5_rst_port", 32'(port), 32'd0);
        checkOutput("t5_rst_flags", {28'd0, step_stb, sync, busy, done}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("t5_no_done", 32'(done_cnt - d0), 32'd0);
        applyStimulus(2'd0, 0, 2, 2);
        waitDone(20, "t5b");
        checkOutput("t5_port_after", 32'(port), 32'h01);
        @(negedge clk);

        // Test 6a: start together with stop in IDLE is ignored
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checkOutput("t6_idle_flags", {29'd0, step_stb, sync, busy}, 32'd0);
        @(negedge clk);
        checkOutput("t6_idle_busy", 32'(busy), 32'd0);
        checkOutput("t6_idle_port", 32'(port), 32'h01);

        // Test 6b: stop coinciding with a divider tick
        applyStimulus(2'd0, 2, 5, 5);
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        sb_q.delete();
        checkOutput("t6_tick_done", 32'(done), 32'd1);
        checkOutput("t6_tick_no_step", 32'(step_stb), 32'd0);
        checkOutput("t6_tick_port", 32'(port), 32'h00);
        @(negedge clk);
        checkOutput("t6_idle_after", {30'd0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
